awb_gain_correct: RTL and testbench
===================================

Name: awb_gain_correct

Overview:
- Gray-world auto white balance stage directly downstream of the Bayer-to-RGB demosaic.
- Consumes the demosaic's RGB888 stream with its vsync/href/de, and accumulates per-channel sums over each frame.
- During vertical blank, computes red and blue gains relative to green with a sequential divider, and applies the committed gains to the next frame.

Parameters:
- ACC_W, 32, width of each per-channel frame accumulator.
- FRAC, 8, fractional bits of the gain (Q2.8 with GAIN_W=10).
- GAIN_W, 10, gain width; GAIN_ONE = 1<<FRAC = 256.
- GAIN_MIN, 64, lower clamp of computed gains (0.25).
- GAIN_MAX, 1023, upper clamp of computed gains (~3.996).

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, reset.
- awb_en, in, 1, 1 = apply computed gains; 0 = unity gains.
- per_img_vsync, in, 1, frame valid, high during active frame.
- per_img_href, in, 1, line valid.
- per_img_de, in, 1, pixel valid.
- per_img_red, in, 8, input R.
- per_img_green, in, 8, input G.
- per_img_blue, in, 8, input B.
- post_img_vsync, out, 1, per_img_vsync delayed 2.
- post_img_href, out, 1, per_img_href delayed 2.
- post_img_de, out, 1, per_img_de delayed 2.
- post_img_red, out, 8, corrected R.
- post_img_green, out, 8, G passthrough.
- post_img_blue, out, 8, corrected B.
- gain_r, out, GAIN_W, active red gain.
- gain_b, out, GAIN_W, active blue gain.
- awb_busy, out, 1, divider FSM not IDLE.

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- On reset: all post_* = 0, gain_r = gain_b = GAIN_ONE, awb_busy = 0, accumulators and pending gains cleared, FSM = IDLE. Reset mid-division aborts the division.
- Apply path, fixed latency 2 clk regardless of de:
  - Stage 1 registers R*gain_r and B*gain_b (8+GAIN_W bits), and registers G.
  - Stage 2 shifts right by FRAC (truncate) and saturates to 255.
  - Sync signals go through a matching 2-deep shift register.
- Statistics:
  - When per_img_vsync & per_img_de, add R/G/B to sum_r/sum_g/sum_b.
  - Each accumulator saturates at all-ones; it never wraps.
- Frame end is the per_img_vsync falling edge, detected against a 1-cycle registered copy.
  - If FSM is IDLE: latch the three sums, clear the accumulators, go to DIV_R.
  - If FSM is busy: discard the sums, clear the accumulators, and let the FSM continue.
- FSM: IDLE -> DIV_R -> DIV_B -> DONE -> IDLE.
  - DIV_R computes q = (sum_g << FRAC) / sum_r: unsigned restoring division, ACC_W+FRAC iterations, one bit per clock.
  - DIV_B computes the same with sum_b as divisor.
  - Divisor = 0 gives result GAIN_ONE.
  - Nonzero results are clamped to [GAIN_MIN, GAIN_MAX].
  - Results go into pending_r/pending_b. DONE sets pending_valid and returns to IDLE.
  - awb_busy = 1 in DIV_R, DIV_B and DONE.
- Commit happens only on the per_img_vsync rising edge (frame start); gains never change inside a frame.
  - awb_en = 1 and pending_valid: gain_r/gain_b <= pending, and pending_valid clears.
  - awb_en = 0: gain_r/gain_b <= GAIN_ONE, and pending_valid is kept.
  - Frame start while the FSM is still busy: old gains are held; the result commits at the following frame start.
- Pixel values with de = 0 still pass through the multiplier, but they are not accumulated.

Decomposition:
- Package awb_pkg holds:
  - the FSM state enum (IDLE, DIV_R, DIV_B, DONE);
  - GAIN_ONE, FRAC, GAIN_MIN and GAIN_MAX defaults;
  - a saturate-to-8-bit function.
- Sub-module awb_seq_divider: unsigned restoring divider.
  - Parameterised width.
  - Handshake: start, dividend, divisor in; done pulse, quotient out; div-by-zero flag.
  - Instantiated once and time-shared between R and B.

Test Plan:
- Reset: assert rst for 3 clk mid-stream -> all post_* = 0, gain_r = gain_b = 256, awb_busy = 0 on the cycle after the reset edge.
- Neutral frame: 4x4 frame with R=G=B=100 and awb_en=1 -> gains stay 256; next frame output equals input exactly, with a 2-cycle lag on data and syncs.
- Cast correction: 4x4 frame with (R,G,B)=(50,100,200) -> after the frame, awb_busy rises, then pending = 512/128; at next vsync rise gain_r=512 and gain_b=128; pixel (50,100,200) outputs (100,100,100).
- Clamp/saturate:
  - Frame with R=10, G=200 -> gain_r=1023.
  - Next frame R=200 -> post R=255.
  - Frame with R=0 -> gain_r=256.
- Frame-boundary rules: a short vblank, where vsync rises while DIV_B is active -> gains unchanged during that frame and committed at the next vsync rise. awb_en=0 at frame start -> gains 256 while the pending result is retained.
- Reset during DIV_R -> FSM IDLE, awb_busy=0, gains 256, no commit at next frame start.

Source files
------------

// File: rtl/awb_gain_correct_pkg.sv
// Shared types, default parameters and helpers for the gray-world AWB stage.
package awb_pkg;

    localparam int ACC_W_DEF    = 32;
    localparam int FRAC_DEF     = 8;
    localparam int GAIN_W_DEF   = 10;
    localparam int GAIN_ONE_DEF = 1 << FRAC_DEF;
    localparam int GAIN_MIN_DEF = 64;
    localparam int GAIN_MAX_DEF = 1023;

    // Gain-computation sequencer: red division, blue division, publish.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_R = 2'd1,
        DIV_B = 2'd2,
        DONE  = 2'd3
    } awb_state_e;

    // Clip a wide unsigned value to an 8-bit pixel.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/awb_gain_correct_if.sv
// RGB888 video stream with frame/line/pixel qualifiers.
interface awb_video_if;
    logic       vsync;
    logic       href;
    logic       de;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output vsync, href, de, red, green, blue);
    modport slave  (input  vsync, href, de, red, green, blue);
endinterface

// File: rtl/awb_gain_correct_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// The quotient shifts into the dividend register as dividend bits leave it.
module awb_seq_divider #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quotient,
    output logic             o_dbz
);
    localparam int CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [DVS_W:0]   w_rem_sh;
    logic             w_ge;
    logic [DVS_W-1:0] w_sub;

    // Partial remainder never reaches the divisor, so the shifted value fits DVS_W+1 bits
    // and the difference (taken only when w_ge) fits DVS_W bits.
    assign w_rem_sh = {r_rem, r_dvd[DVD_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub    = w_rem_sh[DVS_W-1:0] - r_dvs;

    // Load on start, then iterate DVD_W times and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_dvd  <= i_dividend;
                r_dvs  <= i_divisor;
                r_rem  <= '0;
                r_cnt  <= CW'(DVD_W);
                r_busy <= 1'b1;
                r_dbz  <= (i_divisor == '0);
            end else if (r_busy) begin
                r_dvd <= {r_dvd[DVD_W-2:0], w_ge};
                r_rem <= w_ge ? w_sub : w_rem_sh[DVS_W-1:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_dvd;
    assign o_dbz      = r_dbz;

endmodule

// File: rtl/awb_gain_correct.sv
// Gray-world auto white balance: per-frame R/G/B statistics, R and B gains
// relative to G computed in vertical blank, gains committed at frame start.
module awb_gain_correct
    import awb_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int GAIN_W   = GAIN_W_DEF,
    parameter int GAIN_MIN = GAIN_MIN_DEF,
    parameter int GAIN_MAX = GAIN_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              awb_en,
    awb_video_if.slave        per_img,
    awb_video_if.master       post_img,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              awb_busy
);
    localparam int QW = ACC_W + FRAC;
    localparam int MW = 8 + GAIN_W;
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << FRAC);

    // ---------------- apply path ----------------
    logic [MW-1:0]  r_mul_r;
    logic [MW-1:0]  r_mul_b;
    logic [7:0]     r_g1;
    logic [7:0]     r_post_r;
    logic [7:0]     r_post_g;
    logic [7:0]     r_post_b;
    logic [1:0][2:0] r_sync_pipe;   // {vsync, href, de} per stage

    logic [GAIN_W-1:0] r_gain_r;
    logic [GAIN_W-1:0] r_gain_b;

    // Stage 1: multiply by the active gains; de is ignored so latency is fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_r <= '0;
            r_mul_b <= '0;
            r_g1    <= '0;
        end else begin
            r_mul_r <= MW'(per_img.red)  * MW'(r_gain_r);
            r_mul_b <= MW'(per_img.blue) * MW'(r_gain_b);
            r_g1    <= per_img.green;
        end
    end

    // Stage 2: drop the fractional bits and clip to 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_r <= '0;
            r_post_g <= '0;
            r_post_b <= '0;
        end else begin
            r_post_r <= sat8(32'(r_mul_r >> FRAC));
            r_post_g <= r_g1;
            r_post_b <= sat8(32'(r_mul_b >> FRAC));
        end
    end

    // Sync qualifiers travel alongside the data through two stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_pipe <= '0;
        end else begin
            r_sync_pipe[0] <= {per_img.vsync, per_img.href, per_img.de};
            r_sync_pipe[1] <= r_sync_pipe[0];
        end
    end

    assign post_img.vsync = r_sync_pipe[1][2];
    assign post_img.href  = r_sync_pipe[1][1];
    assign post_img.de    = r_sync_pipe[1][0];
    assign post_img.red   = r_post_r;
    assign post_img.green = r_post_g;
    assign post_img.blue  = r_post_b;

    // ---------------- statistics ----------------
    logic             r_vs_d;
    logic             w_frame_start;
    logic             w_frame_end;
    logic             w_acc_en;
    logic [ACC_W-1:0] r_sum_r;
    logic [ACC_W-1:0] r_sum_g;
    logic [ACC_W-1:0] r_sum_b;
    logic [ACC_W-1:0] r_lat_g;
    logic [ACC_W-1:0] r_lat_b;

    awb_state_e r_state;
    awb_state_e w_state_nxt;

    assign w_frame_start = per_img.vsync & ~r_vs_d;
    assign w_frame_end   = ~per_img.vsync & r_vs_d;
    assign w_acc_en      = per_img.vsync & per_img.de;

    // Saturating accumulate: a pinned sum still yields a sensible ratio.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] s, input logic [7:0] p);
        logic [ACC_W:0] t;
        t = {1'b0, s} + (ACC_W+1)'(p);
        return t[ACC_W] ? '1 : t[ACC_W-1:0];
    endfunction

    // Registered vsync for edge detection.
    always_ff @(posedge clk) begin
        if (rst) r_vs_d <= 1'b0;
        else     r_vs_d <= per_img.vsync;
    end

    // Frame accumulators; cleared at every frame end, snapshotted only when the divider is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
            r_lat_g <= '0;
            r_lat_b <= '0;
        end else if (w_frame_end) begin
            if (r_state == IDLE) begin
                r_lat_g <= r_sum_g;
                r_lat_b <= r_sum_b;
            end
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
        end else if (w_acc_en) begin
            r_sum_r <= acc_add(r_sum_r, per_img.red);
            r_sum_g <= acc_add(r_sum_g, per_img.green);
            r_sum_b <= acc_add(r_sum_b, per_img.blue);
        end
    end

    // ---------------- gain computation ----------------
    logic          w_div_start;
    logic [QW-1:0] w_div_dvd;
    logic [ACC_W-1:0] w_div_dvs;
    logic          w_div_done;
    logic [QW-1:0] w_div_q;
    logic          w_div_dbz;

    awb_seq_divider #(
        .DVD_W (QW),
        .DVS_W (ACC_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_div_dvd),
        .i_divisor  (w_div_dvs),
        .o_done     (w_div_done),
        .o_quotient (w_div_q),
        .o_dbz      (w_div_dbz)
    );

    // Quotient to gain: zero divisor means no information, so stay neutral.
    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [QW-1:0] q, input logic dbz);
        if (dbz)                 return GAIN_ONE;
        if (q < QW'(GAIN_MIN))   return GAIN_W'(GAIN_MIN);
        if (q > QW'(GAIN_MAX))   return GAIN_W'(GAIN_MAX);
        return q[GAIN_W-1:0];
    endfunction

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and divider launch. The red division reads the live sums on
    // the frame-end cycle; the blue one uses the snapshot taken then.
    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_div_dvd   = {r_sum_g, {FRAC{1'b0}}};
        w_div_dvs   = r_sum_r;
        case (r_state)
            IDLE: begin
                if (w_frame_end) begin
                    w_state_nxt = DIV_R;
                    w_div_start = 1'b1;
                end
            end
            DIV_R: begin
                if (w_div_done) begin
                    w_state_nxt = DIV_B;
                    w_div_start = 1'b1;
                    w_div_dvd   = {r_lat_g, {FRAC{1'b0}}};
                    w_div_dvs   = r_lat_b;
                end
            end
            DIV_B: begin
                if (w_div_done) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    logic [GAIN_W-1:0] r_pend_r;
    logic [GAIN_W-1:0] r_pend_b;
    logic              r_pend_vld;

    // Pending results and frame-start commit. Disable forces unity at once;
    // a fresh result only lands when the sequencer is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain_r   <= GAIN_ONE;
            r_gain_b   <= GAIN_ONE;
            r_pend_r   <= GAIN_ONE;
            r_pend_b   <= GAIN_ONE;
            r_pend_vld <= 1'b0;
        end else begin
            if (r_state == DIV_R && w_div_done) r_pend_r <= clamp_gain(w_div_q, w_div_dbz);
            if (r_state == DIV_B && w_div_done) r_pend_b <= clamp_gain(w_div_q, w_div_dbz);
            if (r_state == DONE)                r_pend_vld <= 1'b1;
            if (w_frame_start) begin
                if (!awb_en) begin
                    r_gain_r <= GAIN_ONE;
                    r_gain_b <= GAIN_ONE;
                end else if (r_state == IDLE && r_pend_vld) begin
                    r_gain_r   <= r_pend_r;
                    r_gain_b   <= r_pend_b;
                    r_pend_vld <= 1'b0;
                end
            end
        end
    end

    assign gain_r   = r_gain_r;
    assign gain_b   = r_gain_b;
    assign awb_busy = (r_state != IDLE);

endmodule

// File: tb/tb_awb_gain_correct.sv
// Directed bench for awb_gain_correct with a frame-level reference model.
module tb_awb_gain_correct;
    // Two divisions of ACC_W+FRAC single-bit steps each: the sequencer is
    // surely busy before BUSY_MIN cycles and surely idle after BUSY_MAX.
    localparam int BUSY_MIN = 80;
    localparam int BUSY_MAX = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       awb_en;
    logic [9:0] gain_r;
    logic [9:0] gain_b;
    logic       awb_busy;

    awb_video_if per_img ();
    awb_video_if post_img ();

    awb_gain_correct dut (
        .clk      (clk),
        .rst      (rst),
        .awb_en   (awb_en),
        .per_img  (per_img),
        .post_img (post_img),
        .gain_r   (gain_r),
        .gain_b   (gain_b),
        .awb_busy (awb_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int apply_gain(input int p, input int g);
        int v;
        v = (p * g) / 256;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int ratio_gain(input longint num, input longint den);
        longint q;
        if (den == 0) return 256;
        q = (num * 256) / den;
        if (q < 64)   return 64;
        if (q > 1023) return 1023;
        return int'(q);
    endfunction

    longint cyc = 0;
    bit     started = 0;
    int     e1_r, e1_g, e1_b, e2_r, e2_g, e2_b;
    int     e1_s, e2_s;
    int     m_gr = 256, m_gb = 256, m_pr = 256, m_pb = 256;
    bit     m_pv, m_busy, m_vs_d;
    longint m_t0;
    longint m_sr, m_sg, m_sb;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            e1_r = 0; e1_g = 0; e1_b = 0; e1_s = 0;
            e2_r = 0; e2_g = 0; e2_b = 0; e2_s = 0;
            m_gr = 256; m_gb = 256; m_pv = 0; m_busy = 0; m_vs_d = 0;
            m_sr = 0; m_sg = 0; m_sb = 0;
        end else begin
            // every sample emerges two cycles later, scaled by the gain active now
            e2_r = e1_r; e2_g = e1_g; e2_b = e1_b; e2_s = e1_s;
            e1_r = apply_gain(int'(per_img.red), m_gr);
            e1_g = int'(per_img.green);
            e1_b = apply_gain(int'(per_img.blue), m_gb);
            e1_s = int'({per_img.vsync, per_img.href, per_img.de});
            if (m_busy && (cyc - m_t0) >= BUSY_MAX) begin
                m_busy = 0;
                m_pv   = 1;
            end
            if (per_img.vsync && !m_vs_d) begin
                if (!awb_en) begin
                    m_gr = 256; m_gb = 256;
                end else if (!m_busy && m_pv) begin
                    m_gr = m_pr; m_gb = m_pb; m_pv = 0;
                end
            end
            if (!per_img.vsync && m_vs_d) begin
                if (!m_busy) begin
                    m_pr = ratio_gain(m_sg, m_sr);
                    m_pb = ratio_gain(m_sg, m_sb);
                    m_busy = 1;
                    m_t0 = cyc;
                end
                m_sr = 0; m_sg = 0; m_sb = 0;
            end else if (per_img.vsync && per_img.de) begin
                m_sr += per_img.red; m_sg += per_img.green; m_sb += per_img.blue;
            end
            m_vs_d = per_img.vsync;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("post_red",   32'(post_img.red),   e2_r);
            check("post_green", 32'(post_img.green), e2_g);
            check("post_blue",  32'(post_img.blue),  e2_b);
            check("post_sync",  32'({post_img.vsync, post_img.href, post_img.de}), e2_s);
            check("gain_r",     32'(gain_r), m_gr);
            check("gain_b",     32'(gain_b), m_gb);
            if (m_busy && (cyc - m_t0) < BUSY_MIN) check("awb_busy_hi", 32'(awb_busy), 1);
            else if (!m_busy)                      check("awb_busy_lo", 32'(awb_busy), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        per_img.vsync = vs; per_img.href = hs; per_img.de = de;
        per_img.red = r; per_img.green = g; per_img.blue = b;
        @(posedge clk);
        #1;
    endtask

    task automatic vblank(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    // Frame of lines x px constant pixels; the last pixel's output is checked
    // against literal expectations when it emerges.
    task automatic frame(input int lines, input int px, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b,
                         input int er, input int eg, input int eb);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < px; p++) drive(1'b1, 1'b1, 1'b1, r, g, b);
            drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            if (l == lines - 1) begin
                check("px_red",   32'(post_img.red),   er);
                check("px_green", 32'(post_img.green), eg);
                check("px_blue",  32'(post_img.blue),  eb);
                check("px_de",    32'(post_img.de),    1);
            end
            drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        awb_en = 1'b1;
        per_img.vsync = 0; per_img.href = 0; per_img.de = 0;
        per_img.red = 0; per_img.green = 0; per_img.blue = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        vblank(4);

        // reset in the middle of active pixels
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100);
        check("rst_post_red", 32'(post_img.red), 0);
        check("rst_post_de",  32'(post_img.de), 0);
        check("rst_gain_r",   32'(gain_r), 256);
        check("rst_busy",     32'(awb_busy), 0);
        drive(1'b1, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100);
        drive(1'b1, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100);
        rst = 1'b0;
        vblank(10);

        // neutral frame
        frame(4, 4, 8'd100, 8'd100, 8'd100, 100, 100, 100);
        vblank(150);
        frame(4, 4, 8'd100, 8'd100, 8'd100, 100, 100, 100);
        check("neutral_gain_r", 32'(gain_r), 256);
        vblank(150);

        // colour cast
        frame(4, 4, 8'd50, 8'd100, 8'd200, 50, 100, 200);
        vblank(5);
        check("cast_busy", 32'(awb_busy), 1);
        vblank(145);
        frame(4, 4, 8'd50, 8'd100, 8'd200, 100, 100, 100);
        check("cast_gain_r", 32'(gain_r), 512);
        check("cast_gain_b", 32'(gain_b), 128);
        vblank(150);

        // clamp and saturation
        frame(4, 4, 8'd10, 8'd200, 8'd200, 20, 200, 100);
        vblank(150);
        frame(4, 4, 8'd200, 8'd200, 8'd200, 255, 200, 200);
        check("clamp_gain_r", 32'(gain_r), 1023);
        vblank(150);
        frame(4, 4, 8'd0, 8'd100, 8'd100, 0, 100, 100);
        vblank(150);
        frame(4, 4, 8'd50, 8'd100, 8'd200, 50, 100, 200);
        check("zero_r_gain_r", 32'(gain_r), 256);

        // short vblank: next frame starts during the blue division
        vblank(60);
        frame(1, 4, 8'd100, 8'd100, 8'd100, 100, 100, 100);
        check("short_vb_gain_r", 32'(gain_r), 256);
        vblank(150);
        frame(4, 4, 8'd50, 8'd100, 8'd200, 100, 100, 100);
        check("late_gain_r", 32'(gain_r), 512);
        check("late_gain_b", 32'(gain_b), 128);
        vblank(150);

        // disabled at frame start
        awb_en = 1'b0;
        frame(4, 4, 8'd100, 8'd100, 8'd100, 100, 100, 100);
        check("dis_gain_r", 32'(gain_r), 256);
        check("dis_gain_b", 32'(gain_b), 256);
        awb_en = 1'b1;
        vblank(150);

        // reset during the red division
        frame(4, 4, 8'd50, 8'd100, 8'd200, 50, 100, 200);
        vblank(10);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("rst_div_busy",   32'(awb_busy), 0);
        check("rst_div_gain_r", 32'(gain_r), 256);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;
        vblank(150);
        frame(4, 4, 8'd100, 8'd100, 8'd100, 100, 100, 100);
        check("rst_div_no_commit", 32'(gain_r), 256);
        vblank(150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
